// File: rtl/reg_write_arbitration_pkg.sv
// ---------------------------------------------------------------------------
// reg_write_arbitration_pkg
// Shared constants and helpers for the register hold / writeback path.
// The read path's select logic uses the same onehot16 decoder, so both
// sides agree on the bit order of hold and write-enable vectors.
// ---------------------------------------------------------------------------
package reg_write_arbitration_pkg;

    localparam int REG_IDX_W = 4;
    localparam int NREGS     = 16;
    localparam int DATA_W    = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    function automatic logic [NREGS-1:0] onehot16(input reg_idx_t idx);
        logic [NREGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/reg_write_arbitration_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant. A lone request is granted; when both request,
// the source named by prio wins and prio toggles so the other goes next.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           grant enable (low during flush: no grants, prio frozen)
//   req0, req1   requests from source 0 / 1
//   gnt0, gnt1   combinational grants
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic prio;
    logic contested;

    assign contested = en && req0 && req1;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
            if (req0 && req1) begin
                gnt0 = ~prio;
                gnt1 = prio;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (contested) begin
            prio <= ~prio;
        end
    end

endmodule

// File: rtl/reg_write_arbitration.sv
// ---------------------------------------------------------------------------
// reg_write_arbitration
// Owns the 16-bit register hold vector and merges results from the ALU
// (res0) and memory (res1) sources into one register-file write per cycle.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      clears all holds, blocks claims and results
//   claim_valid/reg/ready      dispatch claim of a destination register
//   resN_valid/reg/data/ready  result sources 0 and 1 (valid/ready handshake)
//   wr_en, wr_data             registered one-hot write to the register file
//   hold_Q                     registered per-register hold bits
//   err_unheld                 one-cycle pulse: result for an unheld register
// ---------------------------------------------------------------------------
module reg_write_arbitration #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              claim_valid,
    input  logic [3:0]        claim_reg,
    output logic              claim_ready,
    input  logic              res0_valid,
    input  logic [3:0]        res0_reg,
    input  logic [DATA_W-1:0] res0_data,
    output logic              res0_ready,
    input  logic              res1_valid,
    input  logic [3:0]        res1_reg,
    input  logic [DATA_W-1:0] res1_data,
    output logic              res1_ready,
    output logic [NREGS-1:0]  wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic [NREGS-1:0]  hold_Q,
    output logic              err_unheld
);

    import reg_write_arbitration_pkg::*;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

    logic              gnt0_p0;
    logic              gnt1_p0;
    logic              acc_p0;
    reg_idx_t          sel_idx_p0;
    logic [DATA_W-1:0] sel_data_p0;
    logic              held_p0;

    logic [0:0]        state_p1;
    reg_idx_t          wr_idx_p1;

    logic [NREGS-1:0]  hold_set;
    logic [NREGS-1:0]  hold_nxt;

    // ---- stage p0: arbitration, claim check ----
    rr_arb2 u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (!flush),
        .req0 (res0_valid),
        .req1 (res1_valid),
        .gnt0 (gnt0_p0),
        .gnt1 (gnt1_p0)
    );

    assign res0_ready = gnt0_p0;
    assign res1_ready = gnt1_p0;
    assign acc_p0     = gnt0_p0 || gnt1_p0;

    always_comb begin
        sel_idx_p0  = res0_reg;
        sel_data_p0 = res0_data;
        if (gnt1_p0) begin
            sel_idx_p0  = res1_reg;
            sel_data_p0 = res1_data;
        end
    end

    assign held_p0 = hold_Q[sel_idx_p0];

    // A held register whose write is landing this cycle may be reclaimed
    // immediately; the set below overrides the clear.
    assign claim_ready = claim_valid && !flush &&
                         (!hold_Q[claim_reg] || wr_en[claim_reg]);

    always_comb begin
        hold_set = '0;
        if (claim_ready) begin
            hold_set = onehot16(claim_reg);
        end
        if (flush) begin
            hold_nxt = '0;
        end else begin
            hold_nxt = (hold_Q & ~wr_en) | hold_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_Q <= '0;
        end else begin
            hold_Q <= hold_nxt;
        end
    end

    // ---- stage p1: register-file write ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1   <= ST_IDLE;
            wr_idx_p1  <= '0;
            wr_data    <= '0;
            err_unheld <= 1'b0;
        end else begin
            err_unheld <= acc_p0 && !held_p0;
            if (acc_p0 && held_p0) begin
                state_p1  <= ST_WRITE;
                wr_idx_p1 <= sel_idx_p0;
                wr_data   <= sel_data_p0;
            end else begin
                state_p1  <= ST_IDLE;
            end
        end
    end

    assign wr_en = (state_p1 == ST_WRITE) ? onehot16(wr_idx_p1) : '0;

endmodule

// File: tb/tb_reg_write_arbitration.sv
// ---------------------------------------------------------------------------
// tb_reg_write_arbitration
// Directed, table-driven bench for reg_write_arbitration. Each table row is
// one clock cycle: inputs driven just after the rising edge, combinational
// and registered outputs compared at the falling edge.
// ---------------------------------------------------------------------------
module tb_reg_write_arbitration;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        claim_valid;
    logic [3:0]  claim_reg;
    logic        claim_ready;
    logic        res0_valid;
    logic [3:0]  res0_reg;
    logic [31:0] res0_data;
    logic        res0_ready;
    logic        res1_valid;
    logic [3:0]  res1_reg;
    logic [31:0] res1_data;
    logic        res1_ready;
    logic [15:0] wr_en;
    logic [31:0] wr_data;
    logic [15:0] hold_Q;
    logic        err_unheld;

    int n_total;
    int n_pass;

    reg_write_arbitration #(.DATA_W(32), .NREGS(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .claim_valid(claim_valid),
        .claim_reg  (claim_reg),
        .claim_ready(claim_ready),
        .res0_valid (res0_valid),
        .res0_reg   (res0_reg),
        .res0_data  (res0_data),
        .res0_ready (res0_ready),
        .res1_valid (res1_valid),
        .res1_reg   (res1_reg),
        .res1_data  (res1_data),
        .res1_ready (res1_ready),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .hold_Q     (hold_Q),
        .err_unheld (err_unheld)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        cv;
        logic [3:0]  creg;
        logic        v0;
        logic [3:0]  r0;
        logic [31:0] d0;
        logic        v1;
        logic [3:0]  r1;
        logic [31:0] d1;
        logic        fl;
        logic        ecr;
        logic        er0;
        logic        er1;
        logic [15:0] ewe;
        logic [31:0] ewd;
        logic [15:0] eh;
        logic        eerr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic cv, input logic [3:0] creg,
        input logic v0, input logic [3:0] r0, input logic [31:0] d0,
        input logic v1, input logic [3:0] r1, input logic [31:0] d1,
        input logic fl,
        input logic ecr, input logic er0, input logic er1,
        input logic [15:0] ewe, input logic [31:0] ewd,
        input logic [15:0] eh, input logic eerr);
        vec_t v;
        v.cv = cv;   v.creg = creg;
        v.v0 = v0;   v.r0 = r0;   v.d0 = d0;
        v.v1 = v1;   v.r1 = r1;   v.d1 = d1;
        v.fl = fl;
        v.ecr = ecr; v.er0 = er0; v.er1 = er1;
        v.ewe = ewe; v.ewd = ewd; v.eh = eh; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic cv, input logic [3:0] creg,
                         input logic v0, input logic [3:0] r0, input logic [31:0] d0,
                         input logic v1, input logic [3:0] r1, input logic [31:0] d1,
                         input logic fl);
        claim_valid = cv;  claim_reg = creg;
        res0_valid  = v0;  res0_reg  = r0;  res0_data = d0;
        res1_valid  = v1;  res1_reg  = r1;  res1_data = d1;
        flush       = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        idle();

        // Reset state
        repeat (3) @(posedge clk);
        #4;
        chk("reset wr_en", 32'(wr_en), 32'h0);
        chk("reset wr_data", wr_data, 32'h0);
        chk("reset hold_Q", 32'(hold_Q), 32'h0);
        chk("reset err_unheld", 32'(err_unheld), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // cv creg | v0 r0 d0 | v1 r1 d1 | fl || cr r0r r1r | wr_en wr_data | hold err
        vecs.push_back(mk(1, 3, 0, 0, 0,            0, 0, 0,     0, 1, 0, 0, 16'h0000, 0,            16'h0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0, 0,     0, 0, 0, 0, 16'h0000, 0,            16'h0008, 0));
        vecs.push_back(mk(0, 0, 1, 3, 32'hDEADBEEF, 0, 0, 0,     0, 0, 1, 0, 16'h0000, 0,            16'h0008, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0, 0,     0, 0, 0, 0, 16'h0008, 32'hDEADBEEF, 16'h0008, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0, 0,     0, 0, 0, 0, 16'h0000, 0,            16'h0000, 0));
        // contention, prio starts at res0
        vecs.push_back(mk(1, 1, 0, 0, 0,            0, 0, 0,     0, 1, 0, 0, 16'h0000, 0,            16'h0000, 0));
        vecs.push_back(mk(1, 2, 0, 0, 0,            0, 0, 0,     0, 1, 0, 0, 16'h0000, 0,            16'h0002, 0));
        vecs.push_back(mk(0, 0, 1, 1, 32'h11,       1, 2, 32'h22, 0, 0, 1, 0, 16'h0000, 0,            16'h0006, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,            1, 2, 32'h22, 0, 0, 0, 1, 16'h0002, 32'h11,       16'h0006, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0, 0,     0, 0, 0, 0, 16'h0004, 32'h22,       16'h0004, 0));
        // contention again, prio now favours res1
        vecs.push_back(mk(1, 4, 0, 0, 0,            0, 0, 0,     0, 1, 0, 0, 16'h0000, 0,            16'h0000, 0));
        vecs.push_back(mk(1, 6, 0, 0, 0,            0, 0, 0,     0, 1, 0, 0, 16'h0000, 0,            16'h0010, 0));
        vecs.push_back(mk(0, 0, 1, 4, 32'h44,       1, 6, 32'h66, 0, 0, 0, 1, 16'h0000, 0,            16'h0050, 0));
        vecs.push_back(mk(0, 0, 1, 4, 32'h44,       0, 0, 0,     0, 0, 1, 0, 16'h0040, 32'h66,       16'h0050, 0));
        // clear-and-claim race on r7
        vecs.push_back(mk(1, 7, 0, 0, 0,            0, 0, 0,     0, 1, 0, 0, 16'h0010, 32'h44,       16'h0010, 0));
        vecs.push_back(mk(1, 7, 1, 7, 32'h77,       0, 0, 0,     0, 0, 1, 0, 16'h0000, 0,            16'h0080, 0));
        vecs.push_back(mk(1, 7, 0, 0, 0,            0, 0, 0,     0, 1, 0, 0, 16'h0080, 32'h77,       16'h0080, 0));
        // unheld result on r9
        vecs.push_back(mk(0, 0, 0, 0, 0,            1, 9, 32'hAA, 0, 0, 0, 1, 16'h0000, 0,            16'h0080, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0, 0,     0, 0, 0, 0, 16'h0000, 0,            16'h0080, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0, 0,     0, 0, 0, 0, 16'h0000, 0,            16'h0080, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].cv, vecs[i].creg, vecs[i].v0, vecs[i].r0, vecs[i].d0,
                  vecs[i].v1, vecs[i].r1, vecs[i].d1, vecs[i].fl);
            #4;
            chk($sformatf("row%0d claim_ready", i), 32'(claim_ready), 32'(vecs[i].ecr));
            chk($sformatf("row%0d res0_ready", i), 32'(res0_ready), 32'(vecs[i].er0));
            chk($sformatf("row%0d res1_ready", i), 32'(res1_ready), 32'(vecs[i].er1));
            chk($sformatf("row%0d wr_en", i), 32'(wr_en), 32'(vecs[i].ewe));
            if (vecs[i].ewe != 16'h0) begin
                chk($sformatf("row%0d wr_data", i), wr_data, vecs[i].ewd);
            end
            chk($sformatf("row%0d hold_Q", i), 32'(hold_Q), 32'(vecs[i].eh));
            chk($sformatf("row%0d err_unheld", i), 32'(err_unheld), 32'(vecs[i].eerr));
            @(posedge clk);
            #1;
        end

        // Flush: fill every hold bit (r7 is still held), write r0, then flush
        for (int r = 0; r < 16; r++) begin
            if (r != 7) begin
                drive(1, 4'(r), 0, 0, 0, 0, 0, 0, 0);
                #4;
                chk($sformatf("fill claim r%0d", r), 32'(claim_ready), 32'h1);
                tick();
            end
        end
        idle();
        #4;
        chk("fill hold_Q", 32'(hold_Q), 32'hFFFF);
        tick();
        drive(0, 0, 1, 0, 32'h1234, 0, 0, 0, 0);
        #4;
        chk("flush pre res0_ready", 32'(res0_ready), 32'h1);
        tick();
        drive(1, 3, 1, 1, 32'h5555, 1, 2, 32'h6666, 1);
        #4;
        chk("flush res0_ready", 32'(res0_ready), 32'h0);
        chk("flush res1_ready", 32'(res1_ready), 32'h0);
        chk("flush claim_ready", 32'(claim_ready), 32'h0);
        chk("flush wr_en", 32'(wr_en), 32'h0001);
        chk("flush wr_data", wr_data, 32'h1234);
        tick();
        idle();
        #4;
        chk("post flush hold_Q", 32'(hold_Q), 32'h0000);
        chk("post flush wr_en", 32'(wr_en), 32'h0000);
        tick();

        // prio unaffected by flush: still favours res0
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 2, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 1, 32'hA1, 1, 2, 32'hB2, 0);
        #4;
        chk("post flush contend res0_ready", 32'(res0_ready), 32'h1);
        chk("post flush contend res1_ready", 32'(res1_ready), 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 2, 32'hB2, 0);
        #4;
        chk("post flush res1_ready", 32'(res1_ready), 32'h1);
        chk("post flush wr_data r1", wr_data, 32'hA1);
        tick();
        idle();
        #4;
        chk("post flush wr_en r2", 32'(wr_en), 32'h0004);
        tick();
        tick();

        // Reset asserted while a write is in flight
        drive(1, 3, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 3, 32'hCAFE, 0, 0, 0, 0);
        tick();
        idle();
        #2;
        chk("pre reset wr_en", 32'(wr_en), 32'h0008);
        rst_n = 1'b0;
        #1;
        chk("mid reset wr_en", 32'(wr_en), 32'h0);
        chk("mid reset wr_data", wr_data, 32'h0);
        chk("mid reset hold_Q", 32'(hold_Q), 32'h0);
        chk("mid reset err_unheld", 32'(err_unheld), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        drive(1, 5, 0, 0, 0, 0, 0, 0, 0);
        #4;
        chk("after reset claim r5", 32'(claim_ready), 32'h1);
        tick();
        idle();
        #4;
        chk("after reset hold_Q", 32'(hold_Q), 32'h0020);
        chk("after reset wr_en", 32'(wr_en), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_write_arbitration.md
# reg_write_arbitration

Writeback-side counterpart to the operand read path. Owns the 16-bit register hold (scoreboard) vector and turns results from two execution sources into one register-file write per cycle. Dispatch claims a destination register, which sets its hold bit; the matching result write clears it. The read arbitration consumes `hold_Q` and the register file consumes `wr_en`/`wr_data`.

## Interface
Parameters:
- `DATA_W`, 32, register/result width
- `NREGS`, 16, register count; fixed at 16, with 4-bit register indices

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  pipeline flush; clears all holds and drops pending work
- `claim_valid`  in  1  dispatch requests a destination register
- `claim_reg`  in  4  destination register index
- `claim_ready`  out  1  claim accepted this cycle (combinational)
- `res0_valid` / `res1_valid`  in  1  result source 0 (ALU) / 1 (memory) valid
- `res0_reg` / `res1_reg`  in  4  destination index
- `res0_data` / `res1_data`  in  DATA_W  result value
- `res0_ready` / `res1_ready`  out  1  result accepted this cycle (combinational grant)
- `wr_en`  out  16  one-hot register-file write enable (registered)
- `wr_data`  out  DATA_W  register-file write data (registered)
- `hold_Q`  out  16  per-register hold bits (registered)
- `err_unheld`  out  1  one-cycle pulse: result targeted a register that was not held

## Operation
- Arbitration:
  - One result is accepted per cycle.
  - A lone valid source is granted.
  - When both sources are valid, the one named by the round-robin pointer `prio` is granted.
  - `prio` reset value is 0 (res0 first). `prio` toggles only after a contested grant.
  - Each ready is asserted only when that source is valid and granted.
  - `flush`=1 forces both readys and `claim_ready` to 0.
- Write stage (handshake in cycle N):
  - The write stage registers `wr_en` = one-hot(reg) and `wr_data` = data for cycle N+1 only.
  - The hold bit clears at the end of N+1, the same edge at which the register file captures the data.
  - `wr_en` is 0 in any cycle with no write in flight.
- Unheld result: a result whose register hold bit is 0 at the handshake is still consumed (ready=1). It produces no write (`wr_en` stays 0) and `err_unheld`=1 in N+1.
- Claims:
  - `claim_ready` = `claim_valid` & !`flush` & (hold[claim_reg]==0 OR hold[claim_reg] is clearing this cycle).
  - An accepted claim sets hold[claim_reg] at the cycle end.
  - A claim on a register that is held and not being released is refused; dispatch retries.
- Same register cleared and claimed in one cycle: the set wins. The bit stays 1, and `claim_ready`=1.
- Flush:
  - All hold bits go to 0 at the cycle end.
  - Any write in flight in that cycle still completes (`wr_en` stays asserted), but does not reassert hold.
  - `prio` is unaffected.
- Write stage FSM:
  - States are IDLE and WRITE.
  - IDLE→WRITE on any accepted result to a held register.
  - WRITE→WRITE on back-to-back accepted results.
  - WRITE→IDLE otherwise.
  - Unheld results do not enter WRITE.

## Timing
- Reset values: `wr_en`=0, `wr_data`=0, `hold_Q`=0, `err_unheld`=0, `prio`=0, state IDLE. Combinational outputs follow from the reset state, so readys and `claim_ready` depend only on the inputs.
- Result latency: handshake at N, `wr_en` high during N+1, hold clear visible from N+2.
- Throughput is one write per cycle sustained; no bubble between consecutive writes.
- Reset asserted mid-operation: all state clears immediately and the in-flight write is lost.

## Structure
- The shared package holds:
  - `REG_IDX_W`=4
  - `NREGS`=16
  - `DATA_W`=32
  - `function onehot16(idx)`, shared with the read path's select logic
- One sub-module is natural: `rr_arb2`, holding the 2-way round-robin grant and the `prio` flop.
- Everything else stays flat: hold-vector update, write stage FSM, claim logic.

## Test plan
- **Reset:** assert `rst_n`=0 mid-write → all outputs are 0 immediately. Release, then claim r5 → `claim_ready`=1 and `hold_Q`=0x0020 next cycle.
- **Single write:** claim r3 at cycle 0; res0 sends r3/0xDEADBEEF at cycle 2 → `res0_ready`=1 at 2; `wr_en`=0x0008, `wr_data`=0xDEADBEEF at 3; `hold_Q[3]`=0 from 4.
- **Contention:** r1 and r2 are held; both sources valid from cycle 0 → res0 is granted at 0, res1 at 1. Repeat with r4/r6 → res1 is granted first (`prio` toggled), then res0.
- **Clear-and-claim race:** r7 is held; `wr_en[7]` is high in the same cycle a claim r7 arrives → `claim_ready`=1 and `hold_Q[7]` stays 1. A claim r7 one cycle earlier → `claim_ready`=0.
- **Unheld result:** res1 sends r9 while `hold_Q[9]`=0 → `res1_ready`=1, `wr_en`=0 next cycle, `err_unheld`=1 for exactly one cycle.
- **Flush:** `hold_Q`=0xFFFF and a write to r0 in flight; assert `flush` → both readys and `claim_ready` are 0 that cycle; `wr_en`=0x0001 completes; `hold_Q`=0x0000 next cycle.
